bus_uart_tx: RTL and testbench

- Memory-mapped UART transmitter that responds to the CPU data bus: busAddr, busWData, busRData, Byte_Enable and write strobe.
- Sits behind the address decoder alongside data RAM.
- CPU stores bytes into a TX FIFO; an 8N1 serializer shifts them out on txd at a programmable bit period.
- Reads return data combinationally, so the single-cycle core completes loads in the same cycle.

---
 rtl/bus_uart_tx.sv | 181 ++++++++++++++++++
 tb/tb_bus_uart_tx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: CPU pushes bytes into a TX FIFO through
// a byte-lane bus, and a serializer shifts them out on txd at BAUD_DIV clocks/bit.
module bus_uart_tx #(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        busSel,
  input  logic        busWe,
  input  logic [3:0]  busAddr,
  input  logic [31:0] busWData,
  input  logic [3:0]  Byte_Enable,
  output logic [31:0] busRData,
  output logic        txd,
  output logic        tx_irq
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_BAUD   = 2'd1;
  localparam logic [1:0] REG_TXDATA = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  state_e         state_q, state_d;
  logic [1:0]     ctrl_q, ctrl_d;
  logic [15:0]    baud_q, baud_d;
  logic           overflow_q, overflow_d;
  logic [CW-1:0]  count_q, count_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [7:0]     shift_q, shift_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic [15:0]    timer_q, timer_d;
  logic [15:0]    period_q, period_d;

  logic [7:0]     fifo_mem [FIFO_DEPTH];

  logic           wr_en, push_req, push_ok, pop;
  logic           full, empty, busy, tick;
  logic [15:0]    baud_eff;
  logic [1:0]     reg_sel;
  logic           unused_bits;

  assign unused_bits = ^{busAddr[1:0], busWData[31:16], Byte_Enable[3:2]};

  assign reg_sel  = busAddr[3:2];
  assign wr_en    = busSel & busWe;
  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign busy     = (state_q != S_IDLE);
  assign tick     = (timer_q == 16'd0);
  assign baud_eff = (baud_q == 16'd0) ? 16'd1 : baud_q;

  assign push_req = wr_en & (reg_sel == REG_TXDATA) & Byte_Enable[0];
  assign pop      = (state_q == S_IDLE) & ctrl_q[0] & ~empty;
  // A full FIFO still accepts a push when the serializer frees a slot this cycle.
  assign push_ok  = push_req & (~full | pop);

  // Register file and FIFO bookkeeping.
  always_comb begin
    ctrl_d     = ctrl_q;
    baud_d     = baud_q;
    overflow_d = overflow_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;

    if (wr_en && reg_sel == REG_CTRL && Byte_Enable[0])
      ctrl_d = busWData[1:0];
    if (wr_en && reg_sel == REG_BAUD) begin
      if (Byte_Enable[0]) baud_d[7:0]  = busWData[7:0];
      if (Byte_Enable[1]) baud_d[15:8] = busWData[15:8];
    end
    if (wr_en && reg_sel == REG_STATUS && Byte_Enable[0] && busWData[3])
      overflow_d = 1'b0;
    if (push_req && !push_ok)
      overflow_d = 1'b1;

    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push_ok) count_d = count_q - 1'b1;
  end

  // Serializer FSM: next-state and datapath.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    period_d  = period_q;
    timer_d   = tick ? (period_q - 16'd1) : (timer_q - 16'd1);

    unique case (state_q)
      S_IDLE: begin
        timer_d = timer_q;
        if (pop) begin
          state_d   = S_START;
          shift_d   = fifo_mem[rd_ptr_q];
          period_d  = baud_eff;
          timer_d   = baud_eff - 16'd1;
          bit_idx_d = 3'd0;
        end
      end
      S_START: begin
        if (tick) begin
          state_d   = S_DATA;
          bit_idx_d = 3'd0;
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      ctrl_q     <= 2'b00;
      baud_q     <= DEFAULT_DIV;
      overflow_q <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      shift_q    <= 8'h00;
      bit_idx_q  <= 3'd0;
      timer_q    <= 16'd0;
      period_q   <= 16'd1;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      baud_q     <= baud_d;
      overflow_q <= overflow_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      timer_q    <= timer_d;
      period_q   <= period_d;
    end
  end

  // NOTE: FIFO storage is not reset; the count and pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= busWData[7:0];
  end

  always_comb begin
    busRData = 32'h0;
    if (busSel) begin
      unique case (reg_sel)
        REG_CTRL:   busRData = {30'h0, ctrl_q};
        REG_BAUD:   busRData = {16'h0, baud_q};
        REG_TXDATA: busRData = 32'h0;
        REG_STATUS: busRData = {16'h0, 8'(count_q), 4'h0, overflow_q, busy, empty, full};
        default:    busRData = 32'h0;
      endcase
    end
  end

  assign txd    = (state_q == S_START) ? 1'b0 :
                  (state_q == S_DATA)  ? shift_q[0] : 1'b1;
  assign tx_irq = empty & ctrl_q[1];

endmodule

// File: tb/tb_bus_uart_tx.sv
// Directed self-checking bench for bus_uart_tx: register access, framing,
// FIFO overflow, back-to-back frames and reset behaviour.
module tb_bus_uart_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        busSel;
  logic        busWe;
  logic [3:0]  busAddr;
  logic [31:0] busWData;
  logic [3:0]  Byte_Enable;
  logic [31:0] busRData;
  logic        txd;
  logic        tx_irq;

  int checks = 0;
  int errors = 0;

  bus_uart_tx #(.FIFO_DEPTH(8), .DEFAULT_DIV(16'd868)) dut (
    .clk         (clk),
    .reset       (reset),
    .busSel      (busSel),
    .busWe       (busWe),
    .busAddr     (busAddr),
    .busWData    (busWData),
    .Byte_Enable (Byte_Enable),
    .busRData    (busRData),
    .txd         (txd),
    .tx_irq      (tx_irq)
  );

  always #5 clk = ~clk;

  // Drives a write at the current negedge; it lands on the following posedge.
  task automatic bus_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] be);
    busSel = 1'b1; busWe = 1'b1; busAddr = addr; busWData = data; Byte_Enable = be;
    @(negedge clk);
  endtask

  task automatic bus_idle();
    busSel = 1'b0; busWe = 1'b0; busAddr = 4'h0; busWData = 32'h0; Byte_Enable = 4'h0;
  endtask

  task automatic bus_read(input logic [3:0] addr, output logic [31:0] data);
    busSel = 1'b1; busWe = 1'b0; busAddr = addr; Byte_Enable = 4'h0;
    #1 data = busRData;
  endtask

  task automatic do_reset();
    bus_idle();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    do_reset();
    bus_write(4'h4, 32'd4, 4'b0011);
    bus_write(4'h8, 32'h5A, 4'b0001);
    bus_write(4'h0, 32'h3, 4'b0001);
    bus_idle();
    repeat (9) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b want 1", txd); end
    checks++;
    if (tx_irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", tx_irq); end
    bus_read(4'hC, rd);
    checks++;
    if (rd !== 32'h0000_0002) begin errors++; $display("FAIL reset_status: got %h want 00000002", rd); end
    bus_read(4'h4, rd);
    checks++;
    if (rd !== 32'd868) begin errors++; $display("FAIL reset_baud: got %0d want 868", rd); end
    bus_read(4'h0, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h want 0", rd); end
    busSel = 1'b0; #1;
    checks++;
    if (busRData !== 32'h0) begin errors++; $display("FAIL unselected_read: got %h want 0", busRData); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_byte();
    logic [9:0] frame;
    int busy_cycles;
    bit found;
    frame = {1'b1, 8'hA5, 1'b0};
    busy_cycles = 0;
    found = 1'b0;
    do_reset();
    bus_write(4'h4, 32'd4, 4'b1111);
    bus_write(4'h8, 32'hFFFF_FFA5, 4'b0001);
    bus_write(4'h0, 32'h1, 4'b0001);
    busSel = 1'b1; busWe = 1'b0; busAddr = 4'hC; Byte_Enable = 4'h0;
    for (int i = 0; i < 10; i++) begin
      if (txd === 1'b0) begin found = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!found) begin errors++; $display("FAIL single_start: txd never went low"); end
    for (int k = 0; k < 40; k++) begin
      checks++;
      if (txd !== frame[k/4]) begin
        errors++; $display("FAIL single_bit cycle %0d: got %b want %b", k, txd, frame[k/4]);
      end
      if (busRData[2] === 1'b1) busy_cycles++;
      @(negedge clk);
    end
    checks++;
    if (busy_cycles != 40) begin errors++; $display("FAIL single_busy: got %0d cycles want 40", busy_cycles); end
    checks++;
    if (txd !== 1'b1 || busRData[2] !== 1'b0) begin
      errors++; $display("FAIL single_end: txd %b busy %b want 1 0", txd, busRData[2]);
    end
    bus_idle();
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd;
    do_reset();
    bus_write(4'h8, 32'h0000_5500, 4'b0010);
    bus_idle();
    bus_read(4'hC, rd);
    checks++;
    if (rd !== 32'h0000_0002) begin errors++; $display("FAIL lane_txdata: got %h want 00000002", rd); end
    bus_read(4'h8, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL txdata_read: got %h want 0", rd); end
    bus_write(4'h4, 32'h0000_1234, 4'b0001);
    bus_idle();
    bus_read(4'h4, rd);
    checks++;
    if (rd !== 32'h0000_0334) begin errors++; $display("FAIL lane_baud: got %h want 00000334", rd); end
    bus_write(4'h0, 32'h0000_0003, 4'b0010);
    bus_idle();
    bus_read(4'h0, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL lane_ctrl: got %h want 0", rd); end
  endtask

  task automatic test_overflow();
    logic [31:0] rd;
    do_reset();
    for (int i = 0; i < 9; i++) bus_write(4'h8, 32'(i + 16), 4'b0001);
    bus_idle();
    bus_read(4'hC, rd);
    checks++;
    if (rd !== 32'h0000_0809) begin errors++; $display("FAIL overflow_set: got %h want 00000809", rd); end
    bus_write(4'hC, 32'h8, 4'b0001);
    bus_idle();
    bus_read(4'hC, rd);
    checks++;
    if (rd !== 32'h0000_0801) begin errors++; $display("FAIL overflow_clear: got %h want 00000801", rd); end
  endtask

  task automatic test_back_to_back();
    int starts, ends, t0, t1;
    logic prev, b;
    starts = 0; ends = 0; t0 = 0; t1 = 0; prev = 1'b0;
    do_reset();
    bus_write(4'h4, 32'd2, 4'b0011);
    bus_write(4'h8, 32'h01, 4'b0001);
    bus_write(4'h8, 32'h02, 4'b0001);
    bus_write(4'h0, 32'h3, 4'b0001);
    busSel = 1'b1; busWe = 1'b0; busAddr = 4'hC; Byte_Enable = 4'h0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      #1 b = busRData[2];
      if (b && !prev) begin
        if (starts == 0) begin
          t0 = cyc;
          checks++;
          if (txd !== 1'b0) begin errors++; $display("FAIL b2b_start_txd: got %b want 0", txd); end
        end else t1 = cyc;
        starts++;
      end
      if (!b && prev) ends++;
      prev = b;
      if (ends == 2) break;
      @(negedge clk);
    end
    checks++;
    if (starts != 2 || ends != 2) begin
      errors++; $display("FAIL b2b_frames: starts %0d ends %0d want 2 2", starts, ends);
    end
    checks++;
    if (t1 - t0 != 21) begin errors++; $display("FAIL b2b_gap: got %0d want 21", t1 - t0); end
    checks++;
    if (busRData[1] !== 1'b1 || tx_irq !== 1'b1) begin
      errors++; $display("FAIL b2b_irq: empty %b irq %b want 1 1", busRData[1], tx_irq);
    end
    bus_idle();
  endtask

  task automatic test_full_pop();
    logic [31:0] rd;
    do_reset();
    bus_write(4'h4, 32'd2, 4'b0011);
    for (int i = 0; i < 8; i++) bus_write(4'h8, 32'(i + 32), 4'b0001);
    bus_write(4'h0, 32'h1, 4'b0001);
    bus_write(4'h8, 32'h99, 4'b0001);
    bus_idle();
    bus_read(4'hC, rd);
    checks++;
    if (rd !== 32'h0000_0805) begin errors++; $display("FAIL full_pop: got %h want 00000805", rd); end
    bus_idle();
  endtask

  initial begin
    reset = 1'b0;
    bus_idle();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    test_reset();
    test_single_byte();
    test_byte_lanes();
    test_overflow();
    test_back_to_back();
    test_full_pop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
